serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_subtractor.sv | 28 ++
 rtl/mux8.sv | 10 +
 rtl/serial_sub.sv | 107 ++++++++++
 tb/tb_serial_sub.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Full-subtractor truth tables indexed by {x, y, bin}.
  localparam logic [7:0] SubDiffTable = 8'b1001_0110;
  localparam logic [7:0] SubBoutTable = 8'b1000_1110;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two table-driven 8:1 multiplexers.
module full_subtractor
  import serial_arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic [2:0] sel;

  assign sel = {x, y, bin};

  mux8 u_mux_diff (
    .data_i(SubDiffTable),
    .sel_i (sel),
    .y_o   (diff)
  );

  mux8 u_mux_bout (
    .data_i(SubBoutTable),
    .sel_i (sel),
    .y_o   (bout)
  );

endmodule

// File: rtl/mux8.sv
// Generic 8:1 single-bit multiplexer.
module mux8 (
  input  logic [7:0] data_i,
  input  logic [2:0] sel_i,
  output logic       y_o
);

  assign y_o = data_i[sel_i];

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic fs_diff;
  logic fs_bout;

  full_subtractor u_fs (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (bor_q),
    .diff(fs_diff),
    .bout(fs_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    bor_d   = bor_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          part_d  = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        part_d = {fs_diff, part_q[WIDTH-1:1]};
        bor_d  = fs_bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          diff_d  = part_d;
          bout_d  = fs_bout;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      bor_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      bor_q   <= bor_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
module tb_serial_sub;

  typedef struct {
    int diff;
    int bo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, bo8;
  logic       busy4, done4, bo4;

  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;
  int   errors = 0;
  int   checks = 0;
  int   ndone8 = 0;
  int   ndone4 = 0;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .diff      (diff8),
    .borrow_out(bo8)
  );

  serial_sub #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .a         (a4),
    .b         (b4),
    .busy      (busy4),
    .done      (done4),
    .diff      (diff4),
    .borrow_out(bo4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on integers.
  function automatic exp_t model(input int av, input int bv, input int w);
    exp_t e;
    int   m;
    m      = 1 << w;
    e.diff = (av - bv + m) % m;
    e.bo   = (av < bv) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      ndone8++;
      if (q8.size() == 0) begin
        check("done8_unexpected", 1, 0);
      end else begin
        e8 = q8.pop_front();
        check("diff8", int'(diff8), e8.diff);
        check("borrow8", int'(bo8), e8.bo);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      ndone4++;
      if (q4.size() == 0) begin
        check("done4_unexpected", 1, 0);
      end else begin
        e4 = q4.pop_front();
        check("diff4", int'(diff4), e4.diff);
        check("borrow4", int'(bo4), e4.bo);
      end
    end
  end

  task automatic op8(input int av, input int bv, output int busy_n);
    bit got;
    busy_n = 0;
    got    = 1'b0;
    a8     = av[7:0];
    b8     = bv[7:0];
    start8 = 1'b1;
    q8.push_back(model(av, bv, 8));
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done8) begin
        got = 1'b1;
        break;
      end
      if (busy8) busy_n++;
    end
    if (!got) check("timeout8", 0, 1);
  endtask

  task automatic op4(input int av, input int bv, output int busy_n);
    bit got;
    busy_n = 0;
    got    = 1'b0;
    a4     = av[3:0];
    b4     = bv[3:0];
    start4 = 1'b1;
    q4.push_back(model(av, bv, 4));
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done4) begin
        got = 1'b1;
        break;
      end
      if (busy4) busy_n++;
    end
    if (!got) check("timeout4", 0, 1);
  endtask

  task automatic wait_done8();
    bit got;
    got = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done8) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("timeout8_wait", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    exp_t held;
    rst    = 1'b1;
    start8 = 1'b0;
    start4 = 1'b0;
    a8     = '0;
    b8     = '0;
    a4     = '0;
    b4     = '0;

    repeat (2) @(negedge clk);
    check("reset_busy8", int'(busy8), 0);
    check("reset_done8", int'(done8), 0);
    check("reset_diff8", int'(diff8), 0);
    check("reset_borrow8", int'(bo8), 0);
    check("reset_busy4", int'(busy4), 0);
    check("reset_diff4", int'(diff4), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    op8(100, 37, n);
    check("busy_len_100_37", n, 8);
    op8(5, 10, n);
    op8(0, 1, n);
    op8(255, 255, n);
    check("busy_len_255_255", n, 8);
    repeat (16) begin
      op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), n);
    end
    @(posedge clk);
    #1;

    // Start during RUN must be ignored.
    d0     = ndone8;
    a8     = 8'd9;
    b8     = 8'd4;
    start8 = 1'b1;
    q8.push_back(model(9, 4, 8));
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a8     = 8'd1;
    b8     = 8'd2;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_done_count", ndone8 - d0, 1);
    check("ignored_start_queue", q8.size(), 0);

    // Back-to-back: start held through DONE.
    held   = model(60, 70, 8);
    a8     = 8'd60;
    b8     = 8'd70;
    start8 = 1'b1;
    q8.push_back(held);
    @(posedge clk);
    #1;
    a8 = 8'd200;
    b8 = 8'd3;
    q8.push_back(model(200, 3, 8));
    wait_done8();
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    check("b2b_busy", int'(busy8), 1);
    check("b2b_hold_diff", int'(diff8), held.diff);
    check("b2b_hold_borrow", int'(bo8), held.bo);
    repeat (3) @(negedge clk);
    check("b2b_hold_diff_late", int'(diff8), held.diff);
    wait_done8();
    @(posedge clk);
    #1;

    // Reset in the middle of an operation.
    a8     = 8'd77;
    b8     = 8'd12;
    start8 = 1'b1;
    q8.push_back(model(77, 12, 8));
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    void'(q8.pop_back());
    #1;
    check("midrst_busy", int'(busy8), 0);
    check("midrst_done", int'(done8), 0);
    check("midrst_diff", int'(diff8), 0);
    check("midrst_borrow", int'(bo8), 0);
    d0 = ndone8;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", ndone8 - d0, 0);
    op8(200, 55, n);
    check("busy_len_200_55", n, 8);
    @(posedge clk);
    #1;

    // Exhaustive WIDTH=4.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(i, j, n);
        check("busy_len4", n, 4);
      end
    end
    repeat (3) @(negedge clk);
    check("final_queue8", q8.size(), 0);
    check("final_queue4", q4.size(), 0);
    check("done4_count", ndone4, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
